// File: rtl/jtdsp16_pkg.sv
// Shared JTDSP16 definitions: ROM arbiter FSM states and default ROM
// word-address width.
package jtdsp16_pkg;

  localparam int AW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XREAD = 2'd1,
    ST_FETCH = 2'd2
  } arb_st_t;

endpackage

// File: rtl/jtdsp16_rom_fbuf.sv
// One-word instruction fetch buffer with hit comparator.
// Ports: clk/rst, flush (drop valid), fill/fill_addr/fill_data (load word),
// fetch_addr (PC), hit (buffer holds PC), dout (buffered word).
module jtdsp16_rom_fbuf
  import jtdsp16_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [15:0]   fill_data,
  input  logic [AW-1:0] fetch_addr,
  output logic          hit,
  output logic [15:0]   dout
);

  logic [AW-1:0] fb_addr;
  logic          fb_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fb_addr  <= '0;
      dout     <= '0;
      fb_valid <= 1'b0;
    end else begin
      if (fill) begin
        fb_addr <= fill_addr;
        dout    <= fill_data;
      end
      // flush beats a simultaneous fill: the word lands but stays invalid
      if (flush)
        fb_valid <= 1'b0;
      else if (fill)
        fb_valid <= 1'b1;
    end
  end

  assign hit = fb_valid && (fb_addr == fetch_addr);

endmodule

// File: rtl/jtdsp16_rom_arb.sv
// JTDSP16 program-ROM arbiter: serialises X-space reads and instruction
// fetches onto one rom_cs/rom_ok port and stalls the core via halt.
// Ports: clk, rst, cen, flush; fetch_addr/fetch_dout; x_req/x_addr/x_dout;
// halt; rom_cs/rom_addr/rom_data/rom_ok external ROM handshake.
module jtdsp16_rom_arb
  import jtdsp16_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          flush,
  input  logic [AW-1:0] fetch_addr,
  output logic [15:0]   fetch_dout,
  input  logic          x_req,
  input  logic [AW-1:0] x_addr,
  output logic [15:0]   x_dout,
  output logic          halt,
  output logic          rom_cs,
  output logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_data,
  input  logic          rom_ok
);

  arb_st_t st;
  logic    hit;
  logic    x_done;
  logic    x_need;
  logic    adv;
  logic    fill;
  logic    xfill;
  logic    flush_pend;
  logic    fb_flush;

  assign x_need = x_req && !x_done;
  assign halt   = !hit || x_need;
  assign adv    = cen && !halt;
  assign fill   = (st == ST_FETCH) && rom_ok;
  assign xfill  = (st == ST_XREAD) && rom_ok;

  // a flush seen while a fetch is in flight must also void that word
  assign fb_flush = flush || flush_pend;

  jtdsp16_rom_fbuf #(
    .AW(AW)
  ) u_fbuf (
    .clk       (clk),
    .rst       (rst),
    .flush     (fb_flush),
    .fill      (fill),
    .fill_addr (rom_addr),
    .fill_data (rom_data),
    .fetch_addr(fetch_addr),
    .hit       (hit),
    .dout      (fetch_dout)
  );

  // X has priority: its operand belongs to the instruction in decode
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (x_need) begin
            st       <= ST_XREAD;
            rom_cs   <= 1'b1;
            rom_addr <= x_addr;
          end else if (!hit) begin
            st       <= ST_FETCH;
            rom_cs   <= 1'b1;
            rom_addr <= fetch_addr;
          end
        end
        ST_XREAD, ST_FETCH: begin
          if (rom_ok) begin
            st     <= ST_IDLE;
            rom_cs <= 1'b0;
          end
        end
        default: begin
          st     <= ST_IDLE;
          rom_cs <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      flush_pend <= 1'b0;
    else if ((st == ST_FETCH) && !rom_ok)
      flush_pend <= flush_pend || flush;
    else
      flush_pend <= 1'b0;
  end

  // advance wins over a same-edge completion so a late X word
  // never leaks into the next instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      x_done <= 1'b0;
      x_dout <= '0;
    end else begin
      if (xfill)
        x_dout <= rom_data;
      if (adv)
        x_done <= 1'b0;
      else if (xfill)
        x_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jtdsp16_rom_arb.sv
// Randomised bench for jtdsp16_rom_arb against a transaction-level model
// of the ROM port, fetch buffer and X latch.
module tb_jtdsp16_rom_arb;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cen;
  logic          flush;
  logic [AW-1:0] fetch_addr;
  logic [15:0]   fetch_dout;
  logic          x_req;
  logic [AW-1:0] x_addr;
  logic [15:0]   x_dout;
  logic          halt;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          rom_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtdsp16_rom_arb #(
    .AW(AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .flush     (flush),
    .fetch_addr(fetch_addr),
    .fetch_dout(fetch_dout),
    .x_req     (x_req),
    .x_addr    (x_addr),
    .x_dout    (x_dout),
    .halt      (halt),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rom_ok    (rom_ok)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [15:0] a);
    logic [15:0] r;
    r = a * 16'h9E37;
    return r ^ 16'h5A5A;
  endfunction

  // model: outstanding ROM transaction plus buffer / X latch contents
  bit          m_busy, m_isx, m_fpend, m_fbv, m_xdone;
  logic [15:0] m_addr, m_fba, m_fbd, m_xd;
  bit          hp, adv, pend;
  int          lat, stall;

  task automatic model_reset;
    m_busy  = 0;
    m_isx   = 0;
    m_fpend = 0;
    m_fbv   = 0;
    m_xdone = 0;
    m_addr  = '0;
    m_fba   = '0;
    m_fbd   = '0;
    m_xd    = '0;
  endtask

  // apply one clock edge using the inputs held across it
  task automatic model_step;
    adv = 0;
    if (rst) begin
      model_reset();
    end else begin
      adv = cen && !hp;
      if (m_busy) begin
        if (flush && !m_isx) m_fpend = 1;
        if (rom_ok) begin
          if (m_isx) begin
            m_xd    = rom_data;
            m_xdone = 1;
          end else begin
            m_fbd = rom_data;
            m_fba = m_addr;
            m_fbv = !m_fpend;
          end
          m_busy  = 0;
          m_fpend = 0;
        end
      end else if (x_req && !m_xdone) begin
        m_busy = 1;
        m_isx  = 1;
        m_addr = x_addr;
      end else if (!(m_fbv && m_fba == fetch_addr)) begin
        m_busy = 1;
        m_isx  = 0;
        m_addr = fetch_addr;
      end
      if (flush) m_fbv = 0;
      if (adv) m_xdone = 0;
    end
  endtask

  task automatic drive(input int cyc);
    rst   = (cyc < 3) || ($urandom_range(0, 199) == 0);
    cen   = $urandom_range(0, 3) != 0;
    flush = $urandom_range(0, 63) == 0;
    if (adv) begin
      if ($urandom_range(0, 7) == 0)
        fetch_addr = 16'($urandom_range(0, 63));
      else
        fetch_addr = fetch_addr + 16'd1;
      x_req  = $urandom_range(0, 2) == 0;
      x_addr = 16'h0800 + 16'($urandom_range(0, 15));
    end else begin
      if ($urandom_range(0, 31) == 0)
        fetch_addr = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 63) == 0)
        x_req = 1'b0;
    end
    // ROM slave: random latency, occasionally 7 cycles
    pend = pend && rom_cs;
    if (rom_cs && !pend) begin
      pend = 1;
      lat  = ($urandom_range(0, 7) == 0) ? 7 : $urandom_range(0, 3);
    end
    rom_ok   = 1'b0;
    rom_data = 16'($urandom);
    if (pend) begin
      if (lat == 0) begin
        rom_ok   = 1'b1;
        rom_data = mem(rom_addr);
      end else begin
        lat--;
      end
    end else if (!rom_cs) begin
      // stray strobes while idle must be ignored
      rom_ok = $urandom_range(0, 7) == 0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    cen        = 1'b0;
    flush      = 1'b0;
    x_req      = 1'b0;
    fetch_addr = '0;
    x_addr     = '0;
    rom_ok     = 1'b0;
    rom_data   = '0;
    model_reset();
    hp    = 1;
    adv   = 0;
    pend  = 0;
    lat   = 0;
    stall = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      model_step();
      chk("rom_cs", 32'(rom_cs), 32'(m_busy));
      chk("rom_addr", 32'(rom_addr), 32'(m_addr));
      chk("fetch_dout", 32'(fetch_dout), 32'(m_fbd));
      chk("x_dout", 32'(x_dout), 32'(m_xd));
      drive(cyc);
      #1;
      hp = !(m_fbv && m_fba == fetch_addr) || (x_req && !m_xdone);
      chk("halt", 32'(halt), 32'(hp));
      if (!hp) begin
        chk("fetch_word", 32'(fetch_dout), 32'(mem(fetch_addr)));
        if (x_req)
          chk("x_word", 32'(x_dout), 32'(mem(x_addr)));
      end
      stall = (rst || !hp) ? 0 : stall + 1;
      chk("stall_bound", 32'(stall > 100), 32'(0));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
